// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I widths, constants and fetch FSM state type.
package rv32i_pkg;
    localparam int XLEN = 32;
    localparam int ILEN = 32;
    localparam logic [ILEN-1:0] INSTR_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    typedef enum logic {RUN, FAULT} fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush; head holds its last value while empty.
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] last_q, last_d;
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    count_q, count_d;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_d    = flush ? '0 : push ? inc(wr_q) : wr_q;
        rd_d    = flush ? '0 : pop ? inc(rd_q) : rd_q;
        count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
        head    = count_q != '0 ? mem_q[rd_q] : last_q;
        last_d  = head;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            last_q  <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush)
            mem_q[wr_q] <= din;
    end

    assign count = count_q;
endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: owns the fetch PC, buffers {pc,instr} toward decode, handles redirects
// and the sticky misaligned-redirect fault.
module imem_fetch_ctrl
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int              DEPTH        = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] imem_a,
    input  logic [ILEN-1:0] imem_rd,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_instr,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc
);
    localparam int CW = $clog2(DEPTH + 1);

    fetch_state_e          state_q, state_d;
    logic [XLEN-1:0]       fpc_q, fpc_d, fault_pc_q, fault_pc_d;
    logic [CW-1:0]         count;
    logic [XLEN+ILEN-1:0]  head;
    logic                  pop, push, aligned;

    // Redirect outranks everything: it flushes, cancels any pop and blocks the push.
    always_comb begin
        aligned    = redirect_pc[1:0] == 2'b00;
        pop        = out_valid & out_ready;
        push       = (state_q == RUN) & ~redirect_valid & ((count < CW'(DEPTH)) | pop);
        fpc_d      = redirect_valid ? (aligned ? redirect_pc : fpc_q) : push ? fpc_q + 32'd4 : fpc_q;
        state_d    = redirect_valid ? (aligned ? RUN : FAULT) : state_q;
        fault_pc_d = redirect_valid && !aligned ? redirect_pc : fault_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            fpc_q      <= RESET_VECTOR;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fpc_q      <= fpc_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    fetch_fifo #(.WIDTH(XLEN + ILEN), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop & ~redirect_valid),
        .flush (redirect_valid),
        .din   ({fpc_q, imem_rd}),
        .head  (head),
        .count (count)
    );

    assign imem_a    = fpc_q;
    assign out_valid = count != '0;
    assign out_pc    = head[XLEN+ILEN-1:ILEN];
    assign out_instr = head[ILEN-1:0];
    assign fault     = state_q == FAULT;
    assign fault_pc  = fault_pc_q;
endmodule
